puf_crp_sequencer: RTL and testbench
====================================

// Module: puf_crp_sequencer
// PURPOSE
//  Challenge-response sequencer between the 32-bit UART receiver and the arbiter PUF.
//  Accepts one binary challenge, converts it to Gray code and drives it onto the PUF.
//  Fires NEVAL timed evaluations and majority-votes the response bits.
//  Hands the voted word to the UART transmitter and waits for tx_done before taking the next challenge.
// PARAMETERS
//  WIDTH   32  challenge/response width
//  SETTLE  8   cycles puf_trig is held high per evaluation; response sampled on last one (>=1)
//  NEVAL   3   evaluations per challenge for the majority vote (odd, 1..15)
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst_n       in   1      synchronous reset, active-low
//  chal_valid  in   1      challenge word present (driven from UART rx done)
//  chal_bin    in   WIDTH  binary challenge from UART rx
//  chal_ready  out  1      high only in IDLE; accept = chal_valid & chal_ready at a posedge
//  check       in   1      loopback mode, sampled at accept: echo chal_bin, skip PUF
//  puf_trig    out  1      PUF launch/enable, high during evaluation windows
//  puf_chal    out  WIDTH  Gray-coded challenge to PUF, registered
//  puf_resp    in   WIDTH  raw PUF response
//  tx_start    out  1      one-cycle start pulse to UART tx
//  tx_data     out  WIDTH  word to transmit, stable from tx_start until return to IDLE
//  tx_done     in   1      UART tx finished
//  busy        out  1      high in every state except IDLE
//  unstable    out  1      any bit disagreed across evaluations of the last challenge
// BEHAVIOUR
//  Reset: at any posedge with rst_n=0 -> state IDLE; puf_trig, tx_start, busy, unstable = 0;
//    puf_chal, tx_data and vote counters = 0; chal_ready=1 from the first edge after reset.
//    Reset mid-operation aborts immediately: no tx_start, no partial vote survives.
//  Gray code: g[i] = b[i]^b[i+1] for i<WIDTH-1; g[WIDTH-1] = b[WIDTH-1].
//    puf_chal is loaded at accept and held until the next accept.
//  FSM states: IDLE, EVAL, RELAX, SEND, WAIT_TX.
//  IDLE: chal_ready=1. On accept: latch chal_bin and check, load puf_chal, clear per-bit ones-counters,
//    eval_cnt=0, unstable=0. Next state is SEND if check=1, else EVAL.
//  EVAL: puf_trig=1 for exactly SETTLE cycles. At the edge ending the last cycle: add puf_resp[i]
//    into ones[i] (width clog2(NEVAL+1)); eval_cnt++; go to RELAX.
//  RELAX: puf_trig=0 for exactly 1 cycle (PUF recovery).
//    Next state is EVAL if eval_cnt<NEVAL, else SEND.
//  SEND: tx_start=1 for exactly this cycle; next state is WAIT_TX.
//    tx_data = ones[i] > NEVAL/2 per bit, or the latched chal_bin if check=1.
//    unstable = OR over i of (0 < ones[i] < NEVAL); unstable = 0 if check=1.
//  WAIT_TX: hold tx_data; return to IDLE on the edge where tx_done=1. No timeout, waits indefinitely.
//  Latency: tx_start is high in the cycle starting NEVAL*(SETTLE+1) edges after the accept edge
//    (defaults: 27). With check=1 it is the cycle right after accept.
//  Boundaries:
//    - chal_valid while busy is ignored, not queued.
//    - tx_done outside WAIT_TX is ignored, including the SEND cycle.
//    - check changing after accept has no effect.
//    - NEVAL=1: plain capture, unstable is always 0.
//    - ones counters never exceed NEVAL, so no wrap.
// TESTING
//  T1 defaults, chal_bin=0x0000_0003, puf_resp=0xA5A5_5A5A constant -> puf_chal=0x0000_0002;
//     3 puf_trig pulses of 8 cycles with 1-cycle gaps; tx_start at edge 27; tx_data=0xA5A5_5A5A; unstable=0.
//  T2 responses 0xFFFF_0000, 0xFFFF_FFFF, 0x0000_0000 in evaluations 1..3
//     -> tx_data=0xFFFF_0000, unstable=1.
//  T3 check=1, chal_bin=0x1234_5678 -> puf_trig never high; tx_start on the cycle after accept;
//     tx_data=0x1234_5678; unstable=0.
//  T4 chal_valid held with 0xDEAD_BEEF throughout a busy transaction -> chal_ready=0 until the
//     tx_done edge; 0xDEAD_BEEF accepted only in the following IDLE cycle.
//  T5 rst_n=0 for 1 cycle mid second EVAL -> next edge: puf_trig=0, busy=0, chal_ready=1, no tx_start.
//     Next challenge with resp 0x0F0F_0F0F votes 0x0F0F_0F0F; no stale counts.
//  T6 tx_done pulses in IDLE and in SEND are ignored; WAIT_TX held 1000 cycles without tx_done
//     -> tx_data stable, busy=1; IDLE one edge after tx_done.

Source files
------------

// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer: gray-codes a challenge, majority-votes NEVAL timed PUF evaluations, and hands the result to UART tx.
module puf_crp_sequencer #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 8,
  parameter int NEVAL  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chal_valid,
  input  logic [WIDTH-1:0] chal_bin,
  output logic             chal_ready,
  input  logic             check,
  output logic             puf_trig,
  output logic [WIDTH-1:0] puf_chal,
  input  logic [WIDTH-1:0] puf_resp,
  output logic             tx_start,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_done,
  output logic             busy,
  output logic             unstable
);
  localparam int CW = $clog2(NEVAL + 1);
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {IDLE, EVAL, RELAX, SEND, WAIT_TX} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] set_q, set_d;
  logic [CW-1:0] eval_q, eval_d;
  logic [WIDTH-1:0][CW-1:0] ones_q, ones_d;
  logic [WIDTH-1:0] puf_chal_q, puf_chal_d, tx_data_q, tx_data_d, vote;
  logic unstable_q, unstable_d, unst;
  always_comb begin
    vote = '0;
    unst = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      vote[i] = ones_q[i] > CW'(NEVAL / 2);
      unst = unst | ((ones_q[i] != '0) && (ones_q[i] != CW'(NEVAL)));
    end
  end
  always_comb begin
    state_d    = state_q;
    set_d      = set_q;
    eval_d     = eval_q;
    ones_d     = ones_q;
    puf_chal_d = puf_chal_q;
    tx_data_d  = tx_data_q;
    unstable_d = unstable_q;
    case (state_q)
      IDLE: if (chal_valid) begin
        puf_chal_d = chal_bin ^ (chal_bin >> 1);
        ones_d     = '0;
        eval_d     = '0;
        set_d      = '0;
        unstable_d = 1'b0;
        tx_data_d  = check ? chal_bin : tx_data_q;
        state_d    = check ? SEND : EVAL;
      end
      EVAL: if (set_q == SW'(SETTLE - 1)) begin
        set_d   = '0;
        eval_d  = eval_q + 1'b1;
        for (int i = 0; i < WIDTH; i++) ones_d[i] = ones_q[i] + CW'(puf_resp[i]);
        state_d = RELAX;
      end else set_d = set_q + 1'b1;
      RELAX: if (eval_q < CW'(NEVAL)) state_d = EVAL;
      else begin
        tx_data_d  = vote;
        unstable_d = unst;
        state_d    = SEND;
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: state_d = tx_done ? IDLE : WAIT_TX;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      set_q      <= '0;
      eval_q     <= '0;
      ones_q     <= '0;
      puf_chal_q <= '0;
      tx_data_q  <= '0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      eval_q     <= eval_d;
      ones_q     <= ones_d;
      puf_chal_q <= puf_chal_d;
      tx_data_q  <= tx_data_d;
      unstable_q <= unstable_d;
    end
  end
  assign chal_ready = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign puf_trig   = state_q == EVAL;
  assign tx_start   = state_q == SEND;
  assign puf_chal   = puf_chal_q;
  assign tx_data    = tx_data_q;
  assign unstable   = unstable_q;
endmodule

// File: tb/tb_puf_crp_sequencer.sv
// tb_puf_crp_sequencer: table-driven and randomized checks of puf_crp_sequencer against a vote/timing model.
module tb_puf_crp_sequencer;
  localparam int SETTLE = 8;
  localparam int NEVAL  = 3;
  logic clk, rst_n, chal_valid, check, tx_done;
  logic [31:0] chal_bin, puf_resp;
  logic chal_ready, puf_trig, tx_start, busy, unstable;
  logic [31:0] puf_chal, tx_data;
  logic [31:0] resp [NEVAL];
  logic [31:0] obs_data;
  logic obs_unst;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] bin;
    logic        chk;
    logic [31:0] r0, r1, r2;
    logic [31:0] g;
    logic [31:0] d;
    logic        u;
  } vec_t;
  vec_t tab [5];
  puf_crp_sequencer #(.WIDTH(32), .SETTLE(SETTLE), .NEVAL(NEVAL)) dut (
    .clk(clk), .rst_n(rst_n), .chal_valid(chal_valid), .chal_bin(chal_bin),
    .chal_ready(chal_ready), .check(check), .puf_trig(puf_trig), .puf_chal(puf_chal),
    .puf_resp(puf_resp), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .unstable(unstable)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] gray(input logic [31:0] b);
    logic [31:0] g;
    for (int i = 0; i < 31; i++) g[i] = b[i] ^ b[i+1];
    g[31] = b[31];
    return g;
  endfunction
  // Drives one full challenge and checks per-cycle timing against the evaluation schedule.
  task automatic txn(input logic [31:0] bin, input logic chk_in);
    logic [31:0] ed;
    logic eu, et;
    int cnt, lat, bad, n;
    ed = bin;
    eu = 0;
    if (!chk_in)
      for (int i = 0; i < 32; i++) begin
        cnt = 0;
        for (int k = 0; k < NEVAL; k++) cnt += int'(resp[k][i]);
        ed[i] = cnt * 2 > NEVAL;
        eu = eu | (cnt > 0 && cnt < NEVAL);
      end
    lat = chk_in ? 0 : NEVAL * (SETTLE + 1);
    chal_valid = 1; chal_bin = bin; check = chk_in;
    @(negedge clk);
    chal_valid = 0; check = ~chk_in; chal_bin = $urandom;
    chk("puf_chal", puf_chal, gray(bin));
    bad = 0;
    for (int t = 0; t <= lat; t++) begin
      et = !chk_in && t < lat && (t % (SETTLE + 1)) < SETTLE;
      puf_resp = et ? resp[t / (SETTLE + 1)] : $urandom;
      if (puf_trig !== et || tx_start !== (t == lat) || busy !== 1 || chal_ready !== 0) bad++;
      if (t < lat) @(negedge clk);
    end
    chk("timing", 32'(bad), 0);
    chk("tx_data", tx_data, ed);
    chk("unstable", 32'(unstable), 32'(eu));
    obs_data = tx_data;
    obs_unst = unstable;
    n = $urandom_range(1, 5);
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_data !== ed || busy !== 1 || tx_start !== 0) bad++;
    end
    chk("wait_hold", 32'(bad), 0);
    tx_done = 1;
    @(negedge clk);
    tx_done = 0;
    chk("back_idle", {30'b0, busy, chal_ready}, 32'b01);
  endtask
  initial begin
    int bad;
    tab[0] = '{32'h0000_0003, 0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0000_0002, 32'hA5A5_5A5A, 0};
    tab[1] = '{32'h0000_0055, 0, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_007F, 32'hFFFF_0000, 1};
    tab[2] = '{32'h1234_5678, 1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1111_1111, 32'h1B2E_7D44, 32'h1234_5678, 0};
    tab[3] = '{32'hFFFF_FFFF, 0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h8000_0000, 32'h0F0F_0F0F, 1};
    tab[4] = '{32'h8000_0000, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hC000_0000, 32'h0000_0000, 0};
    rst_n = 0; chal_valid = 0; chal_bin = 0; check = 0; tx_done = 0; puf_resp = 0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {26'b0, chal_ready, busy, puf_trig, tx_start, unstable, 1'b0}, 32'b100000);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_puf_chal", puf_chal, 0);
    rst_n = 1;
    @(negedge clk);
    for (int v = 0; v < 5; v++) begin
      resp[0] = tab[v].r0; resp[1] = tab[v].r1; resp[2] = tab[v].r2;
      txn(tab[v].bin, tab[v].chk);
      chk("tab_data", obs_data, tab[v].d);
      chk("tab_unst", 32'(obs_unst), 32'(tab[v].u));
      chk("tab_gray", puf_chal, tab[v].g);
    end
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < NEVAL; k++) resp[k] = $urandom;
      if ($urandom_range(0, 1) == 1) for (int k = 1; k < NEVAL; k++) resp[k] = resp[0];
      txn($urandom, $urandom_range(0, 3) == 0);
    end
    chal_valid = 1; chal_bin = 32'h1111_0000; check = 1;
    @(negedge clk);
    chal_bin = 32'hDEAD_BEEF; check = 0;
    chk("t4_busy", {30'b0, busy, chal_ready}, 32'b10);
    chk("t4_start", 32'(tx_start), 1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (chal_ready !== 0 || busy !== 1) bad++;
    end
    chk("t4_blocked", 32'(bad), 0);
    tx_done = 1;
    @(negedge clk);
    tx_done = 0;
    chk("t4_idle", 32'(chal_ready), 1);
    chk("t4_hold_chal", puf_chal, gray(32'h1111_0000));
    puf_resp = 32'hFFFF_FFFF;
    @(negedge clk);
    chal_valid = 0;
    chk("t4_accept", puf_chal, gray(32'hDEAD_BEEF));
    chk("t4_trig", 32'(puf_trig), 1);
    repeat (12) @(negedge clk);
    chk("t5_mid_eval", 32'(puf_trig), 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t5_flags", {27'b0, puf_trig, busy, chal_ready, tx_start, unstable}, 32'b00100);
    chk("t5_tx_data", tx_data, 0);
    chk("t5_puf_chal", puf_chal, 0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_start !== 0 || busy !== 0) bad++;
    end
    chk("t5_no_start", 32'(bad), 0);
    for (int k = 0; k < NEVAL; k++) resp[k] = 32'h0F0F_0F0F;
    txn(32'h0000_00FF, 0);
    chk("t5_vote", obs_data, 32'h0F0F_0F0F);
    chk("t5_unst", 32'(obs_unst), 0);
    tx_done = 1;
    @(negedge clk);
    tx_done = 0;
    chk("t6_idle_done", {30'b0, busy, chal_ready}, 32'b01);
    chal_valid = 1; chal_bin = 32'hCAFE_F00D; check = 1;
    @(negedge clk);
    chal_valid = 0; tx_done = 1;
    chk("t6_send", 32'(tx_start), 1);
    @(negedge clk);
    tx_done = 0;
    chk("t6_send_done_ignored", {30'b0, busy, tx_start}, 32'b10);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_data !== 32'hCAFE_F00D || busy !== 1) bad++;
    end
    chk("t6_wait_hold", 32'(bad), 0);
    tx_done = 1;
    @(negedge clk);
    tx_done = 0;
    chk("t6_release", {30'b0, busy, chal_ready}, 32'b01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
